// File: rtl/bus_arbiter.sv
// Two-master (fetch/access) arbiter onto a single memory port with one outstanding
// transaction, starvation guard for fetch and pipeline-flush handling.
`timescale 1ns/100ps
module bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        if_request,
  input  logic        if_req_write,
  input  logic [63:0] if_req_addr,
  input  logic [63:0] if_req_wdata,
  input  logic [7:0]  if_req_mask,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [63:0] if_rsp_data,
  output logic        if_rsp_error,
  input  logic        ma_request,
  input  logic        ma_req_write,
  input  logic [63:0] ma_req_addr,
  input  logic [63:0] ma_req_wdata,
  input  logic [7:0]  ma_req_mask,
  output logic        ma_req_ready,
  output logic        ma_rsp_valid,
  output logic [63:0] ma_rsp_data,
  output logic        ma_rsp_error,
  output logic        s_req_valid,
  output logic        s_req_write,
  output logic [63:0] s_req_addr,
  output logic [63:0] s_req_wdata,
  output logic [7:0]  s_req_mask,
  input  logic        s_req_ready,
  input  logic        s_rsp_valid,
  input  logic [63:0] s_rsp_data,
  input  logic        s_rsp_error,
  output logic        busy
);

  localparam int unsigned CntRaw = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CntW   = (CntRaw < 3) ? 3 : CntRaw;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StGrantIf = 3'd1;
  localparam logic [2:0] StGrantMa = 3'd2;
  localparam logic [2:0] StWaitRsp = 3'd3;
  localparam logic [2:0] StDrain   = 3'd4;

  localparam logic OwnIf = 1'b0;
  localparam logic OwnMa = 1'b1;

  logic [2:0]      state_q, state_d;
  logic            owner_q, owner_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            if_flushed;

  // A fetch response is discarded when the cpu flushes in the same cycle.
  assign if_flushed = (owner_q == OwnIf) && clear;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    unique case (state_q)
      StIdle: begin
        if (ma_request && !(if_request && (starve_q == StarveMax))) begin
          state_d = StGrantMa;
        end else if (if_request) begin
          state_d = StGrantIf;
        end
      end
      StGrantIf: begin
        if (s_req_ready) begin
          owner_d  = OwnIf;
          starve_d = '0;
          state_d  = clear ? StDrain : StWaitRsp;
        end else if (clear) begin
          state_d = StIdle;
        end
      end
      StGrantMa: begin
        if (s_req_ready) begin
          owner_d = OwnMa;
          state_d = StWaitRsp;
          if (if_request && (starve_q < StarveMax)) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      StWaitRsp: begin
        if (s_rsp_valid) begin
          state_d = StIdle;
        end else if (if_flushed) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (s_rsp_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= OwnIf;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    s_req_valid  = 1'b0;
    s_req_write  = 1'b0;
    s_req_addr   = '0;
    s_req_wdata  = '0;
    s_req_mask   = '0;
    if_req_ready = 1'b0;
    ma_req_ready = 1'b0;
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    if_rsp_error = 1'b0;
    ma_rsp_valid = 1'b0;
    ma_rsp_data  = '0;
    ma_rsp_error = 1'b0;
    unique case (state_q)
      StGrantIf: begin
        s_req_valid  = 1'b1;
        s_req_write  = if_req_write;
        s_req_addr   = if_req_addr;
        s_req_wdata  = if_req_wdata;
        s_req_mask   = if_req_mask;
        if_req_ready = s_req_ready;
      end
      StGrantMa: begin
        s_req_valid  = 1'b1;
        s_req_write  = ma_req_write;
        s_req_addr   = ma_req_addr;
        s_req_wdata  = ma_req_wdata;
        s_req_mask   = ma_req_mask;
        ma_req_ready = s_req_ready;
      end
      StWaitRsp: begin
        if (s_rsp_valid && !if_flushed) begin
          if (owner_q == OwnIf) begin
            if_rsp_valid = 1'b1;
            if_rsp_data  = s_rsp_data;
            if_rsp_error = s_rsp_error;
          end else begin
            ma_rsp_valid = 1'b1;
            ma_rsp_data  = s_rsp_data;
            ma_rsp_error = s_rsp_error;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model.
`timescale 1ns/100ps
module tb_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        if_request = 1'b0, if_req_write = 1'b0;
  logic [63:0] if_req_addr = '0, if_req_wdata = '0;
  logic [7:0]  if_req_mask = '0;
  logic        if_req_ready, if_rsp_valid, if_rsp_error;
  logic [63:0] if_rsp_data;
  logic        ma_request = 1'b0, ma_req_write = 1'b0;
  logic [63:0] ma_req_addr = '0, ma_req_wdata = '0;
  logic [7:0]  ma_req_mask = '0;
  logic        ma_req_ready, ma_rsp_valid, ma_rsp_error;
  logic [63:0] ma_rsp_data;
  logic        s_req_valid, s_req_write;
  logic [63:0] s_req_addr, s_req_wdata;
  logic [7:0]  s_req_mask;
  logic        s_req_ready = 1'b0, s_rsp_valid = 1'b0, s_rsp_error = 1'b0;
  logic [63:0] s_rsp_data = '0;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .if_request(if_request), .if_req_write(if_req_write), .if_req_addr(if_req_addr),
    .if_req_wdata(if_req_wdata), .if_req_mask(if_req_mask), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_error(if_rsp_error),
    .ma_request(ma_request), .ma_req_write(ma_req_write), .ma_req_addr(ma_req_addr),
    .ma_req_wdata(ma_req_wdata), .ma_req_mask(ma_req_mask), .ma_req_ready(ma_req_ready),
    .ma_rsp_valid(ma_rsp_valid), .ma_rsp_data(ma_rsp_data), .ma_rsp_error(ma_rsp_error),
    .s_req_valid(s_req_valid), .s_req_write(s_req_write), .s_req_addr(s_req_addr),
    .s_req_wdata(s_req_wdata), .s_req_mask(s_req_mask), .s_req_ready(s_req_ready),
    .s_rsp_valid(s_rsp_valid), .s_rsp_data(s_rsp_data), .s_rsp_error(s_rsp_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request waiting for the memory handshake (m_pend: 0 none, 1 IF, 2 MA),
  // and at most one transaction in flight (m_out) whose response may be discarded.
  int m_pend, m_own, m_starve;
  bit m_out, m_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 0; m_own <= 1; m_starve <= 0; m_out <= 1'b0; m_drop <= 1'b0;
    end else if (m_pend != 0) begin
      if (s_req_ready) begin
        m_out  <= 1'b1;
        m_own  <= m_pend;
        m_drop <= (m_pend == 1) && clear;
        m_pend <= 0;
        if (m_pend == 1) m_starve <= 0;
        else if (if_request) m_starve <= (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      end else if (m_pend == 1 && clear) begin
        m_pend <= 0;
      end
    end else if (m_out) begin
      if (s_rsp_valid) m_out <= 1'b0;
      else if (m_own == 1 && clear) m_drop <= 1'b1;
    end else if (ma_request && !(if_request && m_starve == LIMIT)) begin
      m_pend <= 2;
    end else if (if_request) begin
      m_pend <= 1;
    end
  end

  always @(negedge clk) begin
    logic        e_ifv, e_mav, hit;
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_mask;
    logic        e_write;
    if (rst_n) begin
      e_addr  = (m_pend == 1) ? if_req_addr  : (m_pend == 2) ? ma_req_addr  : 64'd0;
      e_wdata = (m_pend == 1) ? if_req_wdata : (m_pend == 2) ? ma_req_wdata : 64'd0;
      e_mask  = (m_pend == 1) ? if_req_mask  : (m_pend == 2) ? ma_req_mask  : 8'd0;
      e_write = (m_pend == 1) ? if_req_write : (m_pend == 2) ? ma_req_write : 1'b0;
      hit   = m_out && !m_drop && s_rsp_valid && !(m_own == 1 && clear);
      e_ifv = hit && (m_own == 1);
      e_mav = hit && (m_own == 2);
      chk1("m_busy", busy, (m_pend != 0) || m_out);
      chk1("m_s_req_valid", s_req_valid, m_pend != 0);
      chk1("m_s_req_write", s_req_write, e_write);
      chk64("m_s_req_addr", s_req_addr, e_addr);
      chk64("m_s_req_wdata", s_req_wdata, e_wdata);
      chk64("m_s_req_mask", {56'd0, s_req_mask}, {56'd0, e_mask});
      chk1("m_if_req_ready", if_req_ready, (m_pend == 1) && s_req_ready);
      chk1("m_ma_req_ready", ma_req_ready, (m_pend == 2) && s_req_ready);
      chk1("m_if_rsp_valid", if_rsp_valid, e_ifv);
      chk64("m_if_rsp_data", if_rsp_data, e_ifv ? s_rsp_data : 64'd0);
      chk1("m_if_rsp_error", if_rsp_error, e_ifv && s_rsp_error);
      chk1("m_ma_rsp_valid", ma_rsp_valid, e_mav);
      chk64("m_ma_rsp_data", ma_rsp_data, e_mav ? s_rsp_data : 64'd0);
      chk1("m_ma_rsp_error", ma_rsp_error, e_mav && s_rsp_error);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; if_request = 1'b0; ma_request = 1'b0;
    if_req_write = 1'b0; ma_req_write = 1'b0; s_req_ready = 1'b0;
    s_rsp_valid = 1'b0; s_rsp_error = 1'b0; s_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    bit if_acc, ma_acc;

    // Reset state and single fetch transaction.
    do_reset();
    chk1("reset_busy", busy, 1'b0);
    if_request = 1'b1; if_req_addr = 64'h8000_0000; s_req_ready = 1'b1;
    #3 chk1("r31_c0_valid", s_req_valid, 1'b0);
    nxt(); #3;
    chk1("r31_c1_valid", s_req_valid, 1'b1);
    chk64("r31_c1_addr", s_req_addr, 64'h8000_0000);
    chk1("r31_c1_ready", if_req_ready, 1'b1);
    nxt(); if_request = 1'b0; s_req_ready = 1'b0; #3 chk1("r31_c2_busy", busy, 1'b1);
    nxt();
    nxt(); s_rsp_valid = 1'b1; s_rsp_data = 64'h13; #3;
    chk1("r31_c4_rspv", if_rsp_valid, 1'b1);
    chk64("r31_c4_data", if_rsp_data, 64'h13);
    nxt(); s_rsp_valid = 1'b0; #3 chk1("r31_c5_idle", busy, 1'b0);

    // Simultaneous requests: access wins, fetch follows.
    do_reset();
    if_request = 1'b1; if_req_addr = 64'h1000;
    ma_request = 1'b1; ma_req_write = 1'b1; ma_req_addr = 64'h2000;
    ma_req_wdata = 64'hDEAD_BEEF; ma_req_mask = 8'h0F; s_req_ready = 1'b1;
    nxt(); #3;
    chk1("r32_ma_ready", ma_req_ready, 1'b1);
    chk1("r32_if_not_ready", if_req_ready, 1'b0);
    chk1("r32_write", s_req_write, 1'b1);
    chk64("r32_wdata", s_req_wdata, 64'hDEAD_BEEF);
    chk64("r32_mask", {56'd0, s_req_mask}, 64'h0F);
    nxt(); ma_request = 1'b0;
    nxt(); s_rsp_valid = 1'b1; s_rsp_data = 64'h99; #3 chk1("r32_ma_rsp", ma_rsp_valid, 1'b1);
    nxt(); s_rsp_valid = 1'b0;
    nxt(); #3;
    chk1("r32_if_ready", if_req_ready, 1'b1);
    chk64("r32_if_addr", s_req_addr, 64'h1000);
    nxt(); if_request = 1'b0;
    nxt(); s_rsp_valid = 1'b1;
    nxt(); s_rsp_valid = 1'b0;

    // Starvation guard: MA x LIMIT then IF, repeating.
    do_reset();
    if_request = 1'b1; ma_request = 1'b1; s_req_ready = 1'b1; s_rsp_valid = 1'b1;
    repeat (45) begin
      #3;
      if (if_req_ready) order.push_back(1);
      else if (ma_req_ready) order.push_back(2);
      nxt();
    end
    if_request = 1'b0; ma_request = 1'b0; s_rsp_valid = 1'b0;
    chk64("r33_count", 64'(order.size()), 64'd15);
    for (int i = 0; i < 10 && i < order.size(); i++) begin
      chk64($sformatf("r33_grant%0d", i), 64'(order[i]), (i % 5 == 4) ? 64'd1 : 64'd2);
    end

    // Flush after fetch handshake, then access served; flush ignored for access.
    do_reset();
    if_request = 1'b1; if_req_addr = 64'h3000; s_req_ready = 1'b1;
    nxt(); #3 chk1("r34_if_ready", if_req_ready, 1'b1);
    nxt(); if_request = 1'b0; clear = 1'b1;
    nxt(); clear = 1'b0; #3 chk1("r34_drain_busy", busy, 1'b1);
    nxt(); s_rsp_valid = 1'b1; s_rsp_data = 64'h55; #3;
    chk1("r34_no_rsp", if_rsp_valid, 1'b0);
    chk64("r34_data0", if_rsp_data, 64'd0);
    nxt(); s_rsp_valid = 1'b0; ma_request = 1'b1; ma_req_addr = 64'h4000; ma_req_write = 1'b0;
    #3 chk1("r34_idle", busy, 1'b0);
    nxt(); #3 chk1("r34_ma_ready", ma_req_ready, 1'b1);
    nxt(); ma_request = 1'b0; clear = 1'b1;
    nxt(); s_rsp_valid = 1'b1; s_rsp_data = 64'hAA; s_rsp_error = 1'b1; #3;
    chk1("r35_ma_rsp", ma_rsp_valid, 1'b1);
    chk64("r35_ma_data", ma_rsp_data, 64'hAA);
    chk1("r35_ma_err", ma_rsp_error, 1'b1);
    nxt(); clear = 1'b0; s_rsp_valid = 1'b0; s_rsp_error = 1'b0; #3;
    chk1("r35_idle", busy, 1'b0);

    // Short async reset in the middle of a fetch transaction.
    do_reset();
    if_request = 1'b1; s_req_ready = 1'b1;
    nxt();
    nxt(); if_request = 1'b0; s_req_ready = 1'b0;
    #2 rst_n = 1'b0; s_rsp_valid = 1'b1; s_rsp_data = 64'h77;
    #0.5;
    chk1("r36_busy", busy, 1'b0);
    chk1("r36_if_rsp", if_rsp_valid, 1'b0);
    chk64("r36_if_data", if_rsp_data, 64'd0);
    #0.5 rst_n = 1'b1;
    nxt(); #3;
    chk1("r36_stray", if_rsp_valid, 1'b0);
    chk1("r36_idle", busy, 1'b0);
    nxt(); s_rsp_valid = 1'b0;

    // Random traffic; every cycle compared against the model.
    do_reset();
    if_acc = 1'b0; ma_acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!if_request || if_acc) begin
        if_request   = ($urandom_range(0, 2) != 0);
        if_req_write = 1'($urandom_range(0, 1));
        if_req_addr  = {$urandom, $urandom};
        if_req_wdata = {$urandom, $urandom};
        if_req_mask  = 8'($urandom);
      end
      if (!ma_request || ma_acc) begin
        ma_request   = ($urandom_range(0, 2) != 0);
        ma_req_write = 1'($urandom_range(0, 1));
        ma_req_addr  = {$urandom, $urandom};
        ma_req_wdata = {$urandom, $urandom};
        ma_req_mask  = 8'($urandom);
      end
      clear       = ($urandom_range(0, 7) == 0);
      s_req_ready = 1'($urandom_range(0, 1));
      s_rsp_valid = ($urandom_range(0, 2) == 0);
      s_rsp_data  = {$urandom, $urandom};
      s_rsp_error = 1'($urandom_range(0, 1));
      #3;
      if_acc = if_req_ready;
      ma_acc = ma_req_ready;
      nxt();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, max consecutive MA grants while IF waits before IF is forced a grant.
REQ-002 Port clk, input, 1, sole clock, rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port clear, input, 1, pipeline flush from cpu.
REQ-005 Ports if_request / ma_request, input, 1 each, transaction request from fetch / access; held high until the matching req_ready.
REQ-006 Ports if_req_write / ma_req_write, input, 1 each, 1 = write.
REQ-007 Ports if_req_addr / ma_req_addr, input, 64 each, physical byte address.
REQ-008 Ports if_req_wdata / ma_req_wdata, input, 64 each; if_req_mask / ma_req_mask, input, 8 each, byte enables.
REQ-009 Ports if_req_ready / ma_req_ready, output, 1 each, request accepted by memory this cycle.
REQ-010 Ports if_rsp_valid / ma_rsp_valid, output, 1 each; if_rsp_data / ma_rsp_data, output, 64 each; if_rsp_error / ma_rsp_error, output, 1 each.
REQ-011 Ports s_req_valid, s_req_write (output, 1), s_req_addr, s_req_wdata (output, 64), s_req_mask (output, 8), s_req_ready (input, 1): memory-side request.
REQ-012 Ports s_rsp_valid (input, 1), s_rsp_data (input, 64), s_rsp_error (input, 1): memory-side response, no backpressure.
REQ-013 Port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 States IDLE, GRANT_IF, GRANT_MA, WAIT_RSP, DRAIN; owner register (IF/MA) valid in WAIT_RSP and DRAIN.
REQ-015 IDLE: ma_request only -> GRANT_MA; if_request only -> GRANT_IF; both -> GRANT_MA, unless starve_cnt == STARVE_LIMIT -> GRANT_IF; neither -> stay.
REQ-016 Arbitration is registered: a request first seen in IDLE drives s_req_valid exactly one cycle later.
REQ-017 GRANT_x: s_req_* = granted master's fields, s_req_valid = 1; the non-granted master sees req_ready = 0.
REQ-018 GRANT_x with s_req_ready = 1: pulse granted master's req_ready for that cycle, latch owner, go to WAIT_RSP; else hold GRANT_x with fields passed through unchanged.
REQ-019 WAIT_RSP: s_req_valid = 0; on s_rsp_valid, forward s_rsp_data/s_rsp_error to owner's rsp_* in the same cycle (combinational), rsp_valid one cycle wide, next state IDLE.
REQ-020 Exactly one transaction outstanding; a new grant is never issued before the previous response returns to IDLE.
REQ-021 starve_cnt (3 bits minimum, saturating at STARVE_LIMIT): +1 on each MA grant taken while if_request = 1; cleared on any IF grant; unchanged otherwise.
REQ-022 clear in GRANT_IF: withdraw s_req_valid next cycle, go to IDLE, if_req_ready not asserted; if s_req_ready is high in the clear cycle the handshake completes and the FSM goes to DRAIN instead.
REQ-023 clear in WAIT_RSP with owner IF: go to DRAIN; the arriving response is consumed and if_rsp_valid stays 0.
REQ-024 clear has no effect on MA grants or MA-owned transactions; they complete normally.
REQ-025 DRAIN: on s_rsp_valid -> IDLE with no rsp_valid to either master; clear while in DRAIN is ignored.
REQ-026 s_rsp_valid received in IDLE, GRANT_IF or GRANT_MA is ignored and produces no master response.
REQ-027 clear together with s_rsp_valid in WAIT_RSP (owner IF): response is dropped, next state IDLE.
REQ-028 All rsp_data outputs are 0 whenever the matching rsp_valid is 0.

Reset
REQ-029 rst_n low: state IDLE, owner IF, starve_cnt 0, all outputs 0, taking effect immediately without waiting for clk.
REQ-030 Reset mid-transaction abandons it; the first s_rsp_valid after release is ignored per REQ-026.

Verification
REQ-031 if_request with addr 0x80000000, s_req_ready=1, response 3 cycles later with data 0x13 -> s_req_valid at cycle 1, if_req_ready pulse at cycle 1, if_rsp_valid with 0x13 at cycle 4.
REQ-032 if_request and ma_request both raised, write 0xDEADBEEF mask 0x0F -> MA granted first, IF granted after the MA response returns to IDLE.
REQ-033 Both requests held continuously, STARVE_LIMIT=4, MA re-requesting each time -> grant order MA,MA,MA,MA,IF, then repeating.
REQ-034 clear one cycle after if_req_ready, response data 0x55 -> no if_rsp_valid, busy=1 until the response, then IDLE; next ma_request served normally.
REQ-035 clear during MA WAIT_RSP -> ma_rsp_valid still delivered with s_rsp_data and s_rsp_error=1 passed through.
REQ-036 rst_n low for 1 ns during WAIT_RSP, between clock edges -> busy=0 and all outputs 0 immediately; stray response after release is ignored.
